// File: rtl/cpu_clken_gen.sv
// CPU clock-enable generator: divides the 28 MHz master clock into 3.5/7/14/28 MHz
// rising/falling enables, switching speed only on 3.5 MHz period boundaries.
module cpu_clken_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cpu_speed,
  input  logic       slow_req,
  input  logic       hold,
  output logic       clken_p,
  output logic       clken_n,
  output logic       tick3m5,
  output logic [1:0] speed_active,
  output logic       speed_changed
);

  logic [2:0] cnt_reg;
  logic [1:0] spd_reg;
  logic       hold_reg;
  logic       chg_reg;
  logic [1:0] req;
  logic [2:0] phase_mask;
  logic [2:0] half_phase;

  assign req = slow_req ? 2'd0 : ((cpu_speed > 4'd3) ? 2'd3 : cpu_speed[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 3'd0;
      spd_reg  <= 2'd0;
      hold_reg <= 1'b0;
      chg_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 3'd1;
      hold_reg <= hold;
      // Speed is only resampled at the end of a 3.5 MHz period.
      if (cnt_reg == 3'd7) begin
        spd_reg <= req;
        chg_reg <= (req != spd_reg);
      end else begin
        chg_reg <= 1'b0;
      end
    end
  end

  // mask = D-1 and half = D/2; at D=1 both are 0, so the falling enable
  // degenerates to "every cycle" without a special case.
  assign phase_mask = 3'b111 >> spd_reg;
  assign half_phase = 3'b100 >> spd_reg;

  assign clken_p       = rst_n & ~hold_reg & ((cnt_reg & phase_mask) == 3'd0);
  assign clken_n       = rst_n & ~hold_reg & ((cnt_reg & phase_mask) == half_phase);
  assign tick3m5       = rst_n & (cnt_reg == 3'd0);
  assign speed_active  = spd_reg;
  assign speed_changed = chg_reg;

endmodule
